// File: rtl/topk_beat_packer.sv
// Collects K (value,index) pairs and streams them as NBEAT 16-word beats: values first, then indices, zero padded.
// Optional macro TOPK_SORT_CHECK_EN adds an ascending-order checker driving sort_err.
module topk_beat_packer #(
   parameter int K = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [31:0] in_index,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_vec [15:0],
   output logic [31:0] out_count,
   output logic        out_last,
   output logic        busy,
   output logic        sort_err
);

   localparam int NBEAT  = (2 * K) / 16 + 1;
   localparam int NWORD  = NBEAT * 16;
   localparam int CNT_W  = $clog2(K + 1);
   localparam int BEAT_W = $clog2(NBEAT + 1);

   typedef enum logic {
      FILL,
      SEND
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    fill_cnt;
   logic [BEAT_W-1:0]   beat;
   logic [31:0]         data_buf [NWORD];

   logic accept;
   logic handshake;
   logic last_fill;
   logic last_beat;

   assign in_ready  = rst && (state_q == FILL) && !abort;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign handshake = out_valid && out_ready;
   assign last_fill = accept && (fill_cnt == CNT_W'(K - 1));
   assign last_beat = (beat == BEAT_W'(NBEAT - 1));
   assign out_last  = (state_q == SEND) && last_beat;
   assign out_count = {{(32 - BEAT_W){1'b0}}, beat};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort overrides both handshakes and always lands back in FILL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: if (last_fill) state_d = SEND;
         SEND: if (handshake && last_beat) state_d = FILL;
         default: state_d = FILL;
      endcase
      if (abort) state_d = FILL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_cnt <= '0;
         beat     <= '0;
      end else if (abort) begin
         fill_cnt <= '0;
         beat     <= '0;
      end else begin
         if (accept) fill_cnt <= last_fill ? '0 : fill_cnt + CNT_W'(1);
         if (handshake) beat <= last_beat ? '0 : beat + BEAT_W'(1);
      end
   end

   // Pad words above 2K-1 are never written, so they keep their reset value of zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int w = 0; w < NWORD; w++) data_buf[w] <= '0;
      end else if (accept) begin
         for (int w = 0; w < K; w++) begin
            if (fill_cnt == CNT_W'(w)) begin
               data_buf[w]     <= in_data;
               data_buf[K + w] <= in_index;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 16; i++) out_vec[i] = '0;
      for (int b = 0; b < NBEAT; b++) begin
         if (beat == BEAT_W'(b)) begin
            for (int i = 0; i < 16; i++) out_vec[i] = data_buf[b * 16 + i];
         end
      end
   end

`ifdef TOPK_SORT_CHECK_EN
   logic [31:0] prev_data;
   logic        sort_err_q;

   // The first accept of a frame has no predecessor, so it only clears the flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_data  <= '0;
         sort_err_q <= 1'b0;
      end else if (abort) begin
         sort_err_q <= 1'b0;
      end else if (accept) begin
         prev_data <= in_data;
         if (fill_cnt == '0) begin
            sort_err_q <= 1'b0;
         end else if (in_data < prev_data) begin
            sort_err_q <= 1'b1;
         end
      end
   end

   assign sort_err = sort_err_q;
`else
   assign sort_err = 1'b0;
`endif

endmodule
